// File: rtl/m8_pkg.sv
// Shared definitions for the M8 frame-RAM fill path: channel indices, fill depths,
// fill-state encoding and the per-channel slot address map.
package m8_pkg;

  localparam int N_CH    = 5;
  localparam int CH_LCB1 = 0;
  localparam int CH_LCB2 = 1;
  localparam int CH_LCB3 = 2;
  localparam int CH_LCB4 = 3;
  localparam int CH_MCM  = 4;

  localparam int LCB_WRDS_DEF = 128;
  localparam int MCM_WRDS_DEF = 512;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_DONE = 1'b1
  } fill_state_e;

  // LCBs own addr[2]=0 with addr[1:0]=k. MCM owns addr[2]=1: words alternate
  // between lanes 2 and 1, and the second 256 words reuse the block in lanes 0 and 3.
  function automatic logic [9:0] m8_slot_addr(input logic [2:0] ch, input logic [9:0] ptr);
    logic [9:0] addr;
    if (ch == 3'(CH_MCM)) addr = {ptr[7:1], 1'b1, ~ptr[0] ^ ptr[8], ptr[0]};
    else                  addr = {ptr[6:0], 1'b0, ch[1:0]};
    return addr;
  endfunction

endpackage

// File: rtl/m8_rr_arb.sv
// Five-way round-robin arbiter: combinational grant, search starting one past
// the channel granted last.
module m8_rr_arb
  import m8_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [N_CH-1:0] req,
  output logic            gnt_vld,
  output logic [2:0]      gnt_idx
);

  logic [2:0] start;

  // NOTE: every combinational output is given a default before the search so no latch is inferred.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (en && req[(int'(start) + i) % N_CH]) begin
        gnt_vld = 1'b1;
        gnt_idx = 3'((int'(start) + i) % N_CH);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start <= '0;
    end else if (gnt_vld) begin
      start <= (gnt_idx == 3'(N_CH - 1)) ? 3'd0 : gnt_idx + 3'd1;
    end
  end

endmodule

// File: rtl/m8_fill_arbiter.sv
// Fills the idle half of the M8 ping-pong frame RAM from four LCB channels and the MCM,
// restarting on every buffer switch and flagging dropped words and incomplete fills.
module m8_fill_arbiter
  import m8_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 12,
  parameter int LCB_WRDS = LCB_WRDS_DEF,
  parameter int MCM_WRDS = MCM_WRDS_DEF
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   iSwitch,
  input  logic [N_CH-1:0]        iReq,
  input  logic [N_CH*DATA_W-1:0] iData,
  output logic [N_CH-1:0]        oAck,
  output logic                   oWrEn,
  output logic                   oWrSel,
  output logic [ADDR_W-1:0]      oWrAddr,
  output logic [DATA_W-1:0]      oWrData,
  output logic                   oFillDone,
  output logic                   oUnderrun,
  output logic [7:0]             oDropCnt
);

  localparam int PTR_W = 10;

  fill_state_e      state;
  logic             sw_q;
  logic             sw_det;
  logic             arb_en;
  logic             gnt_vld;
  logic [2:0]       gnt_idx;
  logic [PTR_W-1:0] ptr [N_CH];
  logic [N_CH-1:0]  full;
  logic [N_CH-1:0]  fills_last;
  logic             all_full_next;
  logic             sel_full;
  logic [PTR_W-1:0] sel_ptr;
  logic [DATA_W-1:0] sel_data;

  function automatic logic [PTR_W-1:0] ch_limit(input int ch);
    return (ch == CH_MCM) ? PTR_W'(MCM_WRDS) : PTR_W'(LCB_WRDS);
  endfunction

  // No grant in the switch cycle, in DONE, or while reset is asserted.
  assign sw_det = (iSwitch != sw_q);
  assign arb_en = reset && (state == ST_FILL) && !sw_det;

  m8_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (arb_en),
    .req     (iReq),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign oAck = gnt_vld ? (N_CH'(1) << gnt_idx) : '0;

  always_comb begin
    full          = '0;
    fills_last    = '0;
    all_full_next = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      full[c]       = (ptr[c] >= ch_limit(c));
      fills_last[c] = gnt_vld && (int'(gnt_idx) == c) && (ptr[c] == ch_limit(c) - 1'b1);
      if (!(full[c] || fills_last[c])) all_full_next = 1'b0;
    end
    sel_ptr  = ptr[gnt_idx];
    sel_full = full[gnt_idx];
    sel_data = iData[int'(gnt_idx)*DATA_W +: DATA_W];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_FILL;
      sw_q      <= 1'b0;
      oWrEn     <= 1'b0;
      oWrSel    <= 1'b1;
      oWrAddr   <= '0;
      oWrData   <= '0;
      oFillDone <= 1'b0;
      oUnderrun <= 1'b0;
      oDropCnt  <= '0;
      // NOTE: the pointer array is control state and must be reset; it is not data storage.
      for (int c = 0; c < N_CH; c++) ptr[c] <= '0;
    end else begin
      sw_q      <= iSwitch;
      oWrEn     <= 1'b0;
      oUnderrun <= 1'b0;
      if (sw_det) begin
        state     <= ST_FILL;
        oFillDone <= 1'b0;
        oWrSel    <= ~iSwitch;
        oUnderrun <= (state == ST_FILL);
        for (int c = 0; c < N_CH; c++) ptr[c] <= '0;
      end else if (gnt_vld) begin
        if (sel_full) begin
          if (oDropCnt != 8'hFF) oDropCnt <= oDropCnt + 8'd1;
        end else begin
          oWrEn        <= 1'b1;
          oWrAddr      <= ADDR_W'(m8_slot_addr(gnt_idx, sel_ptr));
          oWrData      <= sel_data;
          ptr[gnt_idx] <= sel_ptr + 1'b1;
        end
        if (all_full_next) begin
          state     <= ST_DONE;
          oFillDone <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_m8_fill_arbiter.sv
// Scoreboard bench for m8_fill_arbiter: a per-cycle requester model pushes expected
// RAM writes, and a monitor pops and compares whenever oWrEn is seen.
module tb_m8_fill_arbiter;

  logic        reset;
  logic        clk;
  logic        iSwitch;
  logic [4:0]  iReq;
  logic [59:0] iData;
  logic [4:0]  oAck;
  logic        oWrEn;
  logic        oWrSel;
  logic [9:0]  oWrAddr;
  logic [11:0] oWrData;
  logic        oFillDone;
  logic        oUnderrun;
  logic [7:0]  oDropCnt;

  m8_fill_arbiter dut (
    .reset     (reset),
    .clk       (clk),
    .iSwitch   (iSwitch),
    .iReq      (iReq),
    .iData     (iData),
    .oAck      (oAck),
    .oWrEn     (oWrEn),
    .oWrSel    (oWrSel),
    .oWrAddr   (oWrAddr),
    .oWrData   (oWrData),
    .oFillDone (oFillDone),
    .oUnderrun (oUnderrun),
    .oDropCnt  (oDropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [11:0] data;
    logic        sel;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_errors = 0;

  // Requester / expected-output model
  int   cnt [5];
  int   rr;
  logic m_sel;
  logic m_under;
  logic m_done;
  int   m_drops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lim(input int k);
    return (k == 4) ? 512 : 128;
  endfunction

  function automatic int lcb_addr(input int k, input int n);
    return n * 8 + k;
  endfunction

  // MCM: pairs of words per 8-slot block, lanes 6,5 first pass, then 4,7.
  function automatic int mcm_addr(input int n);
    int q;
    int lo;
    q  = n % 256;
    lo = (n >= 256) ? ((q % 2) ? 3 : 0) : ((q % 2) ? 1 : 2);
    return (q / 2) * 8 + 4 + lo;
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1 && oWrEn === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h with empty scoreboard", oWrAddr, oWrData);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(oWrAddr), 32'(mon_e.addr));
        check("wr_data", 32'(oWrData), 32'(mon_e.data));
        check("wr_sel",  32'(oWrSel),  32'(mon_e.sel));
      end
    end
  end

  // One clock of stimulus, entered and left at posedge+1.
  task automatic cycle(input logic [4:0] mask, input bit toggle);
    int   g;
    logic [4:0] exp_ack;
    wr_t  w;
    if (toggle) iSwitch = ~iSwitch;
    iReq = mask;
    for (int k = 0; k < 5; k++) iData[k*12 +: 12] = {3'(k), 9'(cnt[k])};
    @(negedge clk);
    g = -1;
    if (!toggle && !m_done) begin
      for (int i = 0; i < 5; i++) begin
        if (g < 0 && mask[(rr + i) % 5]) g = (rr + i) % 5;
      end
    end
    exp_ack = (g >= 0) ? 5'(1 << g) : 5'd0;
    check("ack",       32'(oAck),      32'(exp_ack));
    check("underrun",  32'(oUnderrun), 32'(m_under));
    check("cur_sel",   32'(oWrSel),    32'(m_sel));
    check("fill_done", 32'(oFillDone), 32'(m_done));
    check("drop_cnt",  32'(oDropCnt),  32'((m_drops > 255) ? 255 : m_drops));
    m_under = 1'b0;
    if (toggle) begin
      m_under = !m_done;
      m_done  = 1'b0;
      m_sel   = ~iSwitch;
      for (int k = 0; k < 5; k++) cnt[k] = 0;
    end else if (g >= 0) begin
      if (cnt[g] < lim(g)) begin
        w.addr = 10'((g == 4) ? mcm_addr(cnt[g]) : lcb_addr(g, cnt[g]));
        w.data = {3'(g), 9'(cnt[g])};
        w.sel  = m_sel;
        exp_q.push_back(w);
        cnt[g]++;
      end else begin
        m_drops++;
      end
      rr     = (g + 1) % 5;
      m_done = 1'b1;
      for (int k = 0; k < 5; k++) if (cnt[k] < lim(k)) m_done = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    iReq    = '0;
    iSwitch = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    for (int k = 0; k < 5; k++) cnt[k] = 0;
    rr      = 0;
    m_sel   = 1'b1;
    m_under = 1'b0;
    m_done  = 1'b0;
    m_drops = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    iData = '0;
    do_reset();

    // Reset state
    check("rst_wr_sel",    32'(oWrSel),    32'd1);
    check("rst_wr_en",     32'(oWrEn),     32'd0);
    check("rst_ack",       32'(oAck),      32'd0);
    check("rst_fill_done", 32'(oFillDone), 32'd0);
    check("rst_underrun",  32'(oUnderrun), 32'd0);
    check("rst_drop_cnt",  32'(oDropCnt),  32'd0);

    // LCB2 alone: 128 writes at 1,9,17,... then acked drops saturating the counter
    for (int i = 0; i < 128 + 260; i++) cycle(5'b00010, 1'b0);
    cycle(5'b00000, 1'b0);
    check("lcb2_drop_sat", 32'(oDropCnt), 32'd255);

    // Reset while MCM is writing: everything clears at once
    for (int i = 0; i < 4; i++) cycle(5'b10000, 1'b0);
    check("wr_en_before_reset", 32'(oWrEn), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_wr_en",     32'(oWrEn),     32'd0);
    check("async_ack",       32'(oAck),      32'd0);
    check("async_drop_cnt",  32'(oDropCnt),  32'd0);
    check("async_fill_done", 32'(oFillDone), 32'd0);
    do_reset();

    // MCM three words: slots 6,5,14 in half 1
    for (int i = 0; i < 3; i++) cycle(5'b10000, 1'b0);
    cycle(5'b00000, 1'b0);
    cycle(5'b00000, 1'b0);

    // Switch mid-fill with LCB1 at ptr 40; the S-1 write lands in the old half
    do_reset();
    for (int i = 0; i < 40; i++) cycle(5'b00001, 1'b0);
    cycle(5'b00001, 1'b1);
    for (int i = 0; i < 3; i++) cycle(5'b00001, 1'b0);
    // Back-to-back switches, each one handled
    cycle(5'b00001, 1'b1);
    cycle(5'b00001, 1'b1);
    for (int i = 0; i < 2; i++) cycle(5'b00001, 1'b0);
    cycle(5'b00000, 1'b0);

    // All five requesting: strict rotation until the fill completes, then silence
    do_reset();
    for (int i = 0; i < 4000 && !m_done; i++) cycle(5'b11111, 1'b0);
    for (int i = 0; i < 3; i++) cycle(5'b11111, 1'b0);
    check("all_fill_done", 32'(oFillDone), 32'd1);
    check("all_no_ack",    32'(oAck),      32'd0);
    // A switch from DONE is not an underrun
    cycle(5'b00000, 1'b1);
    cycle(5'b00000, 1'b0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
